and_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one registered WIDTH-bit bitwise AND unit among NREQ requesters. Each requester presents its operand pair with a request. The block grants one requester, latches its operands, and computes `a & b` in a registered stage. It then holds the result with the winner's index until the consumer accepts it. It sits between the logic-exercise masters and the single shared AND datapath.

---
 rtl/and_share_arb.sv | 153 +++++++++++++++
 tb/tb_and_share_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/and_share_arb.sv
// ---------------------------------------------------------------------------
// and_share_arb
//
// Shares a single registered WIDTH-bit bitwise AND unit among NREQ
// requesters. One requester is granted at a time. Its operands are latched
// on the grant edge, and the result is computed one cycle later. The result
// is then held, together with the winner's index, until the consumer
// accepts it.
//
// Parameters:
//   NREQ   number of requesters (2..16)
//   WIDTH  operand / result width
//   IDW    width of o_id, derived from NREQ (do not override)
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst_n    asynchronous active-low reset
//   req      per-requester level request
//   a_in     packed operand a, requester i at [i*WIDTH +: WIDTH]
//   b_in     packed operand b, same packing
//   gnt      registered one-hot grant pulse (one cycle per grant)
//   o        a & b of the granted requester
//   o_id     index of the requester that owns o
//   o_valid  result valid, held until accepted
//   o_ready  consumer accepts the result when high together with o_valid
//
// Build option:
//   AND_SHARE_ARB_FIXED_PRI_EN  when defined, the lowest asserted index
//                               always wins and no rotation state is kept.
//                               When undefined, arbitration is round-robin.
// ---------------------------------------------------------------------------
module and_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      o,
    output logic [IDW-1:0]        o_id,
    output logic                  o_valid,
    input  logic                  o_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   win;
    logic             any_req;
    logic [WIDTH-1:0] a_l;
    logic [WIDTH-1:0] b_l;

    assign any_req = |req;

    // -----------------------------------------------------------------------
    // Winner selection
    // -----------------------------------------------------------------------
`ifdef AND_SHARE_ARB_FIXED_PRI_EN
    // Scan from the top down so the lowest asserted index is written last.
    always_comb begin
        // NOTE: every always_comb output gets a default first; otherwise a
        // path that leaves it unassigned infers a latch.
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) win = IDW'(i);
        end
    end
`else
    logic [IDW-1:0] last;

    // Scan offsets from farthest to nearest so the first asserted index
    // after 'last' is the one written last and wins.
    always_comb begin
        win = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NREQ]) win = IDW'((int'(last) + k) % NREQ);
        end
    end

    // Reset to NREQ-1 so requester 0 has first priority after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IDW'(NREQ - 1);
        end else if (state_q == IDLE && any_req) begin
            last <= win;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = EXEC;
            EXEC:    state_d = WAIT;
            WAIT:    if (o_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: grant, operand capture, registered AND, result hold
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt     <= '0;
            a_l     <= '0;
            b_l     <= '0;
            o       <= '0;
            o_id    <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt  <= NREQ'(1) << win;
                        a_l  <= a_in[int'(win)*WIDTH +: WIDTH];
                        b_l  <= b_in[int'(win)*WIDTH +: WIDTH];
                        o_id <= win;
                    end
                end
                EXEC: begin
                    gnt     <= '0;
                    o       <= a_l & b_l;
                    o_valid <= 1'b1;
                end
                WAIT: begin
                    if (o_ready) o_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_and_share_arb.sv
// ---------------------------------------------------------------------------
// tb_and_share_arb
//
// Directed bench for and_share_arb (NREQ=4, WIDTH=8). Stimulus pushes the
// expected {o, o_id} of every operation into a queue; a monitor pops and
// compares whenever the consumer accepts a result. Grant, handshake and
// reset behaviour is checked inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_and_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      o;
    logic [IDW-1:0]        o_id;
    logic                  o_valid;
    logic                  o_ready;

    and_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .o       (o),
        .o_id    (o_id),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] o;
        logic [IDW-1:0]   id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_in[idx*WIDTH +: WIDTH] = a;
        b_in[idx*WIDTH +: WIDTH] = b;
    endtask

    task automatic push(input logic [WIDTH-1:0] eo, input int id);
        exp_t e;
        e.o  = eo;
        e.id = IDW'(id);
        sb.push_back(e);
    endtask

    // One complete operation by a single requester with o_ready held high.
    task automatic single_op(input int idx, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] eo);
        set_ops(idx, a, b);
        req = NREQ'(1) << idx;
        push(eo, idx);
        step();
        check("single_gnt", gnt, NREQ'(1) << idx);
        req = '0;
        step();
        check("single_valid_rise", o_valid, 1);
        step();
        check("single_valid_fall", o_valid, 0);
    endtask

    // Scoreboard monitor: compare on every accepted result.
    always @(negedge clk) begin
        if (rst_n && o_valid && o_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_o", o, e.o);
                check("sb_o_id", o_id, e.id);
            end
        end
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Hand-computed operand tables for the all-request tests.
    logic [WIDTH-1:0] ta [NREQ] = '{8'h0F, 8'hF0, 8'hAA, 8'hAA};
    logic [WIDTH-1:0] tb [NREQ] = '{8'h3C, 8'h3C, 8'h55, 8'hFF};
    logic [WIDTH-1:0] te [NREQ] = '{8'h0C, 8'h30, 8'h00, 8'hAA};

    initial begin
        int exp_seq5 [5];
        int exp_seq3 [3];
        logic [WIDTH-1:0] tt_a [5] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hA5};
        logic [WIDTH-1:0] tt_b [5] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h3C};
        logic [WIDTH-1:0] tt_o [5] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h24};

`ifdef AND_SHARE_ARB_FIXED_PRI_EN
        exp_seq5 = '{0, 0, 0, 0, 0};
        exp_seq3 = '{1, 1, 1};
`else
        exp_seq5 = '{0, 1, 2, 3, 0};
        exp_seq3 = '{1, 2, 1};
`endif

        rst_n   = 1'b0;
        req     = '0;
        a_in    = '0;
        b_in    = '0;
        o_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // ---- Reset state ----
        check("rst_gnt", gnt, 0);
        check("rst_o", o, 0);
        check("rst_o_id", o_id, 0);
        check("rst_o_valid", o_valid, 0);
        rst_n = 1'b1;
        step();

        // ---- Reset mid-WAIT discards the pending result ----
        set_ops(1, 8'hFF, 8'hFF);
        req = 4'b0010;
        step();
        check("midwait_gnt", gnt, 4'b0010);
        req = '0;
        step();
        check("midwait_valid", o_valid, 1);
        step();
        check("midwait_held", o_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midwait_rst_valid", o_valid, 0);
        check("midwait_rst_gnt", gnt, 0);
        check("midwait_rst_o", o, 0);
        check("midwait_rst_o_id", o_id, 0);
        step();
        // Requesters 0 and 1 both ask: requester 0 must win after reset.
        o_ready = 1'b1;
        set_ops(0, 8'h5A, 8'hF0);
        set_ops(1, 8'h11, 8'h11);
        req   = 4'b0011;
        rst_n = 1'b1;
        push(8'h50, 0);
        step();
        check("post_rst_gnt", gnt, 4'b0001);
        req = '0;
        step();
        step();

        // ---- Truth table via requester 2, other slices hold decoys ----
        set_ops(0, 8'hFF, 8'hFF);
        set_ops(1, 8'hFF, 8'hFF);
        set_ops(3, 8'hFF, 8'hFF);
        for (int i = 0; i < 5; i++) single_op(2, tt_a[i], tt_b[i], tt_o[i]);

        // ---- All requesting after reset: rotation and 3-cycle cadence ----
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_ops(i, ta[i], tb[i]);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            push(te[exp_seq5[g]], exp_seq5[g]);
            step();
            check("rr_gnt", gnt, NREQ'(1) << exp_seq5[g]);
            step();
            check("rr_gnt_pulse", gnt, 0);
            step();
        end

        // ---- Requesters 1 and 2 only ----
        req = 4'b0110;
        for (int g = 0; g < 3; g++) begin
            push(te[exp_seq3[g]], exp_seq3[g]);
            step();
            check("pair_gnt", gnt, NREQ'(1) << exp_seq3[g]);
            step();
            step();
        end
        req = '0;

        // ---- Backpressure: result held, no new grant ----
        o_ready = 1'b0;
        set_ops(3, 8'hC6, 8'h5F);
        req = 4'b1000;
        push(8'h46, 3);
        step();
        check("bp_gnt", gnt, 4'b1000);
        req = 4'b0001;
        step();
        check("bp_valid_rise", o_valid, 1);
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_valid_held", o_valid, 1);
            check("bp_o_held", o, 8'h46);
            check("bp_id_held", o_id, 3);
            check("bp_no_gnt", gnt, 0);
        end
        o_ready = 1'b1;
        push(te[0], 0);
        step();
        check("bp_valid_drop", o_valid, 0);
        check("bp_no_gnt_yet", gnt, 0);
        step();
        check("bp_next_gnt", gnt, 4'b0001);
        req = '0;
        step();
        step();

        // ---- Operand change during the grant cycle has no effect ----
        set_ops(2, 8'hC3, 8'hFF);
        req = 4'b0100;
        push(8'hC3, 2);
        step();
        check("late_gnt", gnt, 4'b0100);
        set_ops(2, 8'h00, 8'h00);
        req = '0;
        step();
        step();

        // ---- Everything issued must have been observed ----
        repeat (3) step();
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
